// File: rtl/load_unit.sv
// Assembles pairs of received UART bytes (high byte first) into memory words and writes them sequentially.
// Optional inter-byte timeout abort is enabled by defining LOAD_UNIT_TIMEOUT_EN.
module load_unit #(
    parameter int                          ADDR_SIZE         = 13,
    parameter int                          IAGC_STATUS_SIZE  = 4,
    parameter int                          SAMPLER_DATA_SIZE = 16,
    parameter int                          UART_DATA_SIZE    = 8,
    parameter logic [IAGC_STATUS_SIZE-1:0] LOAD_STATUS       = 4'd7,
    parameter int                          TIMEOUT_CYCLES    = 1000000
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic [IAGC_STATUS_SIZE-1:0]  i_iagc_status,
    input  logic [ADDR_SIZE-1:0]         i_memory_size,
    input  logic [UART_DATA_SIZE-1:0]    i_data,
    input  logic                         i_valid,
    output logic [SAMPLER_DATA_SIZE-1:0] o_data,
    output logic [ADDR_SIZE-1:0]         o_addr,
    output logic                         o_wen,
    output logic                         o_end,
    output logic                         o_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_HI = 3'd1,
        WAIT_LO = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                       state;
    logic [ADDR_SIZE-1:0]         count;
    logic [ADDR_SIZE-1:0]         size_reg;
    logic [SAMPLER_DATA_SIZE-1:0] word;
    logic                         in_load;
    logic                         in_wait;
    logic                         timeout_hit;

    assign in_load = (i_iagc_status == LOAD_STATUS);
    assign in_wait = (state == WAIT_HI) || (state == WAIT_LO);

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] timer;

    // Timer only runs while waiting for a byte; any received byte restarts it.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            timer <= '0;
        end else if (!in_wait || i_valid) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout_hit = in_wait && !i_valid && (timer == TIMEOUT_LAST);

    // Error is sticky until the FSM drops back to IDLE on a status change.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            o_error <= 1'b0;
        end else if ((state != IDLE) && !in_load) begin
            o_error <= 1'b0;
        end else if (timeout_hit) begin
            o_error <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_error     = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            count    <= '0;
            size_reg <= '0;
            word     <= '0;
            o_data   <= '0;
            o_addr   <= '0;
            o_wen    <= 1'b0;
            o_end    <= 1'b0;
        end else begin
            o_wen <= 1'b0;
            o_end <= 1'b0;
            if (state == IDLE) begin
                if (in_load) begin
                    count    <= '0;
                    word     <= '0;
                    size_reg <= i_memory_size;
                    if (i_memory_size == '0) begin
                        state <= DONE;
                        o_end <= 1'b1;
                    end else begin
                        state <= WAIT_HI;
                    end
                end
            end else if (!in_load) begin
                // Status change aborts from any active state, dropping any partial word.
                state <= IDLE;
                count <= '0;
                word  <= '0;
            end else begin
                case (state)
                    WAIT_HI: begin
                        if (i_valid) begin
                            word[SAMPLER_DATA_SIZE-1:UART_DATA_SIZE] <= i_data;
                            state <= WAIT_LO;
                        end else if (timeout_hit) begin
                            state <= DONE;
                        end
                    end
                    WAIT_LO: begin
                        if (i_valid) begin
                            word[UART_DATA_SIZE-1:0] <= i_data;
                            o_data <= {word[SAMPLER_DATA_SIZE-1:UART_DATA_SIZE], i_data};
                            o_addr <= count;
                            o_wen  <= 1'b1;
                            state  <= WRITE;
                        end else if (timeout_hit) begin
                            state <= DONE;
                        end
                    end
                    WRITE: begin
                        count <= count + 1'b1;
                        if ((count + 1'b1) == size_reg) begin
                            state <= DONE;
                            o_end <= 1'b1;
                        end else begin
                            state <= WAIT_HI;
                        end
                    end
                    default: begin
                        state <= DONE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit; the timeout check adapts to LOAD_UNIT_TIMEOUT_EN.
module tb_load_unit;

    logic        i_clock;
    logic        i_reset_n;
    logic [3:0]  i_iagc_status;
    logic [12:0] i_memory_size;
    logic [7:0]  i_data;
    logic        i_valid;
    logic [15:0] o_data;
    logic [12:0] o_addr;
    logic        o_wen;
    logic        o_end;
    logic        o_error;

    int errors = 0;
    int checks = 0;

    logic [12:0] wr_addr [16];
    logic [15:0] wr_data [16];
    int wr_count = 0;
    int end_count = 0;
    int cycle = 0;
    int last_wen_cycle = 0;
    int first_end_cycle = 0;

    load_unit #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_iagc_status(i_iagc_status),
        .i_memory_size(i_memory_size),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .o_data       (o_data),
        .o_addr       (o_addr),
        .o_wen        (o_wen),
        .o_end        (o_end),
        .o_error      (o_error)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Log every write and end pulse mid-cycle so scenarios can inspect them afterwards.
    always @(negedge i_clock) begin
        cycle = cycle + 1;
        if (i_reset_n) begin
            if (o_wen) begin
                if (wr_count < 16) begin
                    wr_addr[wr_count] = o_addr;
                    wr_data[wr_count] = o_data;
                end
                wr_count = wr_count + 1;
                last_wen_cycle = cycle;
            end
            if (o_end) begin
                if (end_count == 0) first_end_cycle = cycle;
                end_count = end_count + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge i_clock);
        #1;
        i_data  = b;
        i_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_log();
        wr_count  = 0;
        end_count = 0;
    endtask

    task automatic start_load(input logic [12:0] size);
        clear_log();
        i_memory_size = size;
        i_iagc_status = 4'd7;
        wait_cycles(2);
    endtask

    task automatic stop_load();
        i_iagc_status = 4'd0;
        wait_cycles(3);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_reset_n     = 1'b0;
        i_iagc_status = 4'd0;
        i_memory_size = 13'd0;
        i_data        = 8'd0;
        i_valid       = 1'b0;
        wait_cycles(3);
        checkOutput("rst_wen",   32'(o_wen),   32'd0);
        checkOutput("rst_end",   32'(o_end),   32'd0);
        checkOutput("rst_error", 32'(o_error), 32'd0);
        checkOutput("rst_data",  32'(o_data),  32'd0);
        checkOutput("rst_addr",  32'(o_addr),  32'd0);
        i_reset_n = 1'b1;
        wait_cycles(2);

        // Scenario 1: three full words
        start_load(13'd3);
        applyStimulus(8'h12); applyStimulus(8'h34);
        applyStimulus(8'hAB); applyStimulus(8'hCD);
        applyStimulus(8'h00); applyStimulus(8'hFF);
        wait_cycles(5);
        checkOutput("s1_count", 32'(wr_count), 32'd3);
        checkOutput("s1_addr0", 32'(wr_addr[0]), 32'd0);
        checkOutput("s1_data0", 32'(wr_data[0]), 32'h1234);
        checkOutput("s1_addr1", 32'(wr_addr[1]), 32'd1);
        checkOutput("s1_data1", 32'(wr_data[1]), 32'hABCD);
        checkOutput("s1_addr2", 32'(wr_addr[2]), 32'd2);
        checkOutput("s1_data2", 32'(wr_data[2]), 32'h00FF);
        checkOutput("s1_end",   32'(end_count), 32'd1);
        checkOutput("s1_end_after_wen", 32'(first_end_cycle == last_wen_cycle + 1), 32'd1);
        checkOutput("s1_hold_data", 32'(o_data), 32'h00FF);
        checkOutput("s1_hold_addr", 32'(o_addr), 32'd2);
        wait_cycles(4);
        checkOutput("s1_end_no_repeat", 32'(end_count), 32'd1);
        stop_load();

        // Scenario 2: zero-length load
        start_load(13'd0);
        wait_cycles(3);
        checkOutput("s2_writes", 32'(wr_count), 32'd0);
        checkOutput("s2_end",    32'(end_count), 32'd1);
        stop_load();

        // Scenario 3: abort after five bytes, then a fresh load restarts at 0
        start_load(13'd4);
        applyStimulus(8'h11); applyStimulus(8'h22);
        applyStimulus(8'h33); applyStimulus(8'h44);
        applyStimulus(8'h55);
        stop_load();
        checkOutput("s3_writes", 32'(wr_count), 32'd2);
        checkOutput("s3_addr1",  32'(wr_addr[1]), 32'd1);
        checkOutput("s3_data1",  32'(wr_data[1]), 32'h3344);
        checkOutput("s3_no_end", 32'(end_count), 32'd0);
        start_load(13'd1);
        applyStimulus(8'hA5); applyStimulus(8'h5A);
        wait_cycles(3);
        checkOutput("s3_re_writes", 32'(wr_count), 32'd1);
        checkOutput("s3_re_addr",   32'(wr_addr[0]), 32'd0);
        checkOutput("s3_re_data",   32'(wr_data[0]), 32'hA55A);
        checkOutput("s3_re_end",    32'(end_count), 32'd1);
        stop_load();

        // Scenario 4: reset between high and low byte
        start_load(13'd2);
        applyStimulus(8'h77);
        i_reset_n = 1'b0;
        i_data    = 8'h66;
        i_valid   = 1'b1;
        wait_cycles(2);
        i_valid = 1'b0;
        checkOutput("s4_wen",   32'(o_wen),  32'd0);
        checkOutput("s4_data",  32'(o_data), 32'd0);
        checkOutput("s4_addr",  32'(o_addr), 32'd0);
        checkOutput("s4_end",   32'(o_end),  32'd0);
        checkOutput("s4_state", 32'(dut.state), 32'd0);
        checkOutput("s4_writes", 32'(wr_count), 32'd0);
        i_reset_n = 1'b1;
        wait_cycles(2);
        applyStimulus(8'h88); applyStimulus(8'h99);
        wait_cycles(2);
        checkOutput("s4_re_writes", 32'(wr_count), 32'd1);
        checkOutput("s4_re_addr",   32'(wr_addr[0]), 32'd0);
        checkOutput("s4_re_data",   32'(wr_data[0]), 32'h8899);
        stop_load();

        // Scenario 6: abort coincident with the low byte
        start_load(13'd2);
        applyStimulus(8'h12);
        @(posedge i_clock);
        #1;
        i_data        = 8'h34;
        i_valid       = 1'b1;
        i_iagc_status = 4'd0;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        wait_cycles(3);
        checkOutput("s6_writes", 32'(wr_count), 32'd0);
        checkOutput("s6_state",  32'(dut.state), 32'd0);

        // Scenario 5: single byte followed by a long silence
        start_load(13'd2);
        applyStimulus(8'hC3);
        wait_cycles(110);
`ifdef LOAD_UNIT_TIMEOUT_EN
        checkOutput("s5_error", 32'(o_error), 32'd1);
        checkOutput("s5_state", 32'(dut.state), 32'd4);
`else
        checkOutput("s5_error", 32'(o_error), 32'd0);
        checkOutput("s5_state", 32'(dut.state), 32'd2);
`endif
        checkOutput("s5_no_end",  32'(end_count), 32'd0);
        checkOutput("s5_writes",  32'(wr_count), 32'd0);
        stop_load();
        checkOutput("s5_error_clr", 32'(o_error), 32'd0);
        checkOutput("s5_idle", 32'(dut.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
